// File: rtl/boxcar_interpolator_pkg.sv
// rtl/boxcar_interpolator_pkg.sv - shared DSP constants and elaboration helpers for the boxcar filters
package boxcar_interpolator_pkg;

    // True when n is a power of two no smaller than 2; used to reject bad rate factors at elaboration.
    function automatic bit is_valid_rate_factor(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/boxcar_interpolator.sv
// rtl/boxcar_interpolator.sv - first-order CIC linear-interpolating upsampler
module boxcar_interpolator
    import boxcar_interpolator_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int INTERP_FACTOR = 4,
    parameter int LOG2_FACTOR   = $clog2(INTERP_FACTOR)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_ce,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_ce,
    output logic                  o_overrun
);

    localparam int ACC_WIDTH   = DATA_WIDTH + LOG2_FACTOR + 1;
    localparam int DELTA_WIDTH = DATA_WIDTH + 1;
    localparam logic [LOG2_FACTOR-1:0] LAST_COUNT = LOG2_FACTOR'(INTERP_FACTOR - 1);

    generate
        if (!is_valid_rate_factor(INTERP_FACTOR)) begin : g_bad_factor
            $error("boxcar_interpolator: INTERP_FACTOR must be a power of two >= 2");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                        state_q;
    state_t                        state_d;
    logic signed [DATA_WIDTH-1:0]  prev_q;
    logic signed [DELTA_WIDTH-1:0] delta_q;
    logic signed [ACC_WIDTH-1:0]   acc_q;
    logic [LOG2_FACTOR-1:0]        count_q;
    logic                          overrun_q;

    logic                          accept;
    logic                          last_out;
    logic signed [DELTA_WIDTH-1:0] new_delta;
    logic signed [ACC_WIDTH-1:0]   new_acc;

    // Comb stage: the low-rate difference is one bit wider so it can never wrap.
    assign new_delta = $signed({i_data[DATA_WIDTH-1], i_data}) - DELTA_WIDTH'(prev_q);

    // Seed the integrator one step past prev so the first output already moves toward the new sample.
    assign new_acc = (ACC_WIDTH'(prev_q) <<< LOG2_FACTOR) + ACC_WIDTH'(new_delta);

    assign last_out = (count_q == LAST_COUNT);

    // Normalised gain: drop the LOG2_FACTOR fractional bits; the result always fits DATA_WIDTH.
    assign o_data    = acc_q[LOG2_FACTOR +: DATA_WIDTH];
    assign o_overrun = overrun_q;

    // Next-state, handshake and output strobe decode.
    always_comb begin
        state_d = state_q;
        o_ready = 1'b0;
        o_ce    = 1'b0;
        case (state_q)
            IDLE: o_ready = 1'b1;
            BUSY: begin
                o_ready = last_out;
                o_ce    = !i_reset;
            end
            default: o_ready = 1'b1;
        endcase
        accept = i_ce && o_ready && !i_reset;
        if (accept) begin
            state_d = BUSY;
        end else if (state_q == BUSY && last_out) begin
            state_d = IDLE;
        end
    end

    // State register plus comb/integrator/counter datapath.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            prev_q    <= '0;
            delta_q   <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            overrun_q <= i_ce && !o_ready;
            if (accept) begin
                delta_q <= new_delta;
                acc_q   <= new_acc;
                prev_q  <= $signed(i_data);
                count_q <= '0;
            end else if (state_q == BUSY && !last_out) begin
                acc_q   <= acc_q + ACC_WIDTH'(delta_q);
                count_q <= count_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_boxcar_interpolator.sv
// tb/tb_boxcar_interpolator.sv - directed self-checking bench for boxcar_interpolator
module tb_boxcar_interpolator;

    logic       clk;
    logic       reset;
    logic       ce_in;
    logic [7:0] data_in;
    logic       ready;
    logic [7:0] data_out;
    logic       ce_out;
    logic       overrun;

    int passed;
    int total;

    boxcar_interpolator #(
        .DATA_WIDTH   (8),
        .INTERP_FACTOR(4)
    ) dut (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_ce     (ce_in),
        .i_data   (data_in),
        .o_ready  (ready),
        .o_data   (data_out),
        .o_ce     (ce_out),
        .o_overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ce_in = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic check_out(input string tag, input int ce_e, input int data_e, input int rdy_e);
        check({tag, "_ce"}, 32'(ce_out), ce_e);
        check({tag, "_data"}, 32'($signed(data_out)), data_e);
        check({tag, "_ready"}, 32'(ready), rdy_e);
    endtask

    task automatic accept(input int value);
        ce_in   = 1'b1;
        data_in = 8'(value);
        #1;
        check("accept_ready", 32'(ready), 1);
        tick();
        ce_in = 1'b0;
        #1;
    endtask

    initial begin
        passed  = 0;
        total   = 0;
        reset   = 1'b1;
        ce_in   = 1'b0;
        data_in = 8'd0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check_out("reset", 0, 0, 1);
        check("reset_overrun", 32'(overrun), 0);

        // Ramp 0 -> 8, then idle with held output.
        accept(8);
        check_out("up_k1", 1, 2, 0);
        tick(); check_out("up_k2", 1, 4, 0);
        tick(); check_out("up_k3", 1, 6, 0);
        tick(); check_out("up_k4", 1, 8, 1);
        tick(); check_out("up_idle", 0, 8, 1);
        tick(); check_out("up_hold", 0, 8, 1);

        // Back-to-back: 8 then 0 accepted on the last-output cycle.
        do_reset();
        accept(8);
        tick(); tick(); tick();
        check_out("b2b_k4", 1, 8, 1);
        accept(0);
        check_out("b2b_k5", 1, 6, 0);
        tick(); check_out("b2b_k6", 1, 4, 0);
        tick(); check_out("b2b_k7", 1, 2, 0);
        tick(); check_out("b2b_k8", 1, 0, 1);
        tick(); check_out("b2b_idle", 0, 0, 1);

        // Negative ramp with arithmetic floor.
        do_reset();
        accept(-5);
        check_out("neg_k1", 1, -2, 0);
        tick(); check_out("neg_k2", 1, -3, 0);
        tick(); check_out("neg_k3", 1, -4, 0);
        tick(); check_out("neg_k4", 1, -5, 1);

        // Full-scale swing -128 -> 127, delta 255 must not wrap.
        do_reset();
        accept(-128);
        check_out("fs_k1", 1, -32, 0);
        tick(); check_out("fs_k2", 1, -64, 0);
        tick(); check_out("fs_k3", 1, -96, 0);
        tick(); check_out("fs_k4", 1, -128, 1);
        accept(127);
        check_out("fs_k5", 1, -65, 0);
        tick(); check_out("fs_k6", 1, -1, 0);
        tick(); check_out("fs_k7", 1, 63, 0);
        tick(); check_out("fs_k8", 1, 127, 1);

        // Dropped sample while busy raises a single overrun pulse.
        do_reset();
        accept(8);
        check_out("ovr_k1", 1, 2, 0);
        tick();
        ce_in   = 1'b1;
        data_in = 8'd99;
        #1;
        check_out("ovr_k2", 1, 4, 0);
        tick();
        ce_in = 1'b0;
        #1;
        check_out("ovr_k3", 1, 6, 0);
        check("ovr_pulse", 32'(overrun), 1);
        tick(); check_out("ovr_k4", 1, 8, 1);
        check("ovr_clear", 32'(overrun), 0);
        tick(); check_out("ovr_idle", 0, 8, 1);
        accept(8);
        check_out("ovr_prev_k1", 1, 8, 0);
        tick(); tick(); tick();
        check_out("ovr_prev_k4", 1, 8, 1);

        // Reset mid-burst, with a simultaneous strobe that must be ignored.
        do_reset();
        accept(8);
        check_out("rst_k1", 1, 2, 0);
        tick();
        reset   = 1'b1;
        ce_in   = 1'b1;
        data_in = 8'd50;
        tick();
        reset = 1'b0;
        ce_in = 1'b0;
        #1;
        check_out("rst_after", 0, 0, 1);
        check("rst_no_overrun", 32'(overrun), 0);
        accept(4);
        check_out("rst_k1b", 1, 1, 0);
        tick(); check_out("rst_k2b", 1, 2, 0);
        tick(); check_out("rst_k3b", 1, 3, 0);
        tick(); check_out("rst_k4b", 1, 4, 1);
        tick(); check_out("rst_idle", 0, 4, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
